vector_load_unit: RTL and testbench
===================================

# vector_load_unit

Multi-cycle load/writeback stage sitting directly upstream of the register file. It fetches one word per lane from data memory, assembles a vector (or a single scalar word), then issues exactly one write to the register file. It drives the register file write port (`regWrEnSc`, `regWrEnVec`, `regToWrite`, `dataIn`) and tolerates variable memory latency through a valid handshake.

## Interface
Parameters:
- `registerSize`, 16, bits per lane / memory word
- `selectionBits`, 4, register index width
- `vectorSize`, 4, lanes per vector
- `registerQuantity`, 4, number of vector registers (indices `0..registerQuantity-1`)
- `addrWidth`, 16, memory address width

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `start` in 1: load request, sampled only while `busy`=0
- `isVector` in 1: 1 = vector load, 0 = scalar load
- `destReg` in `selectionBits`: destination register index
- `baseAddr` in `addrWidth`: address of lane 0
- `memRd` out 1: memory read request
- `memAddr` out `addrWidth`: current lane address
- `memRdData` in `registerSize`: read data
- `memValid` in 1: `memRdData` valid this cycle
- `regWrEnSc` out 1: scalar write enable to register file
- `regWrEnVec` out 1: vector write enable to register file
- `regToWrite` out `selectionBits`: write index
- `dataIn` out `vectorSize*registerSize`: packed write data, lane 0 in LSBs
- `busy` out 1: operation in progress
- `done` out 1: one-cycle pulse, coincident with the write
- `err` out 1: one-cycle pulse, illegal request rejected

## Operation
- States: IDLE, FETCH, WRITE.
- IDLE and `start`=1: latch `isVector`, `destReg`, `baseAddr`, and clear the lane counter and assembly buffer.
  - Legal request: go to FETCH.
  - Illegal request: assert `err` for the next cycle, stay in IDLE, no memory or register traffic.
- Legality:
  - Vector: `destReg` < `registerQuantity`.
  - Scalar: `destReg` >= `registerQuantity` and `destReg` != 12. Register 12 is the read-only zero register.
- FETCH:
  - `memRd`=1, `memAddr` = base + lane×stride, truncated mod 2^`addrWidth` (wraps).
  - On each cycle with `memValid`=1: store `memRdData` into lane[counter] and increment the counter.
  - Lane count is `vectorSize` for a vector load, 1 for a scalar load.
  - After the last capture, go to WRITE.
  - `memValid` outside FETCH is ignored.
- WRITE (exactly one cycle):
  - Vector load: `regWrEnVec`=1.
  - Scalar load: `regWrEnSc`=1, word in lane 0, other lanes 0. The register file broadcasts it.
  - `regToWrite`=`destReg`, `done`=1; next state is IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `regWrEnSc` and `regWrEnVec` are never both high.

## Timing
- Reset values: `memRd`=0, `memAddr`=0, `regWrEnSc`=0, `regWrEnVec`=0, `regToWrite`=0, `dataIn`=0, `busy`=0, `done`=0, `err`=0, state IDLE, lane buffer cleared.
- `reset` in any state, including mid-FETCH: next cycle is IDLE, partial data is discarded, and no write is issued.
- All outputs are registered.
- With `start` sampled at edge T and `memValid` held high:
  - FETCH runs cycles T+1..T+N, where N = lanes.
  - WRITE occurs in cycle T+N+1 (vector: T+5, scalar: T+2).
  - Each memValid-low cycle adds one cycle.
- `busy`=1 from T+1 through the WRITE cycle. A new `start` is accepted in the first cycle after WRITE.
- `dataIn` and `regToWrite` hold their last written values after WRITE. Only the enables pulse.
- The register file samples the write at the clock edge ending the WRITE cycle, so data is readable on the next cycle.

## Configuration
- `VLOAD_STRIDE_EN` defined:
  - Adds input port `stride` (`addrWidth` bits), latched with `start`.
  - Lane address = base + lane×stride, wrapping.
- Not defined: no `stride` port; stride is fixed at 1.
- Scalar loads use only lane 0, so stride has no effect on them in either configuration.

## Test plan
- Vector load, `destReg`=3, base 0x0010, memory returns 0xBEEF, 0xDEAD, 0x1234, 0x5678 with `memValid` always high.
  - `memAddr` steps 0x10..0x13.
  - `regWrEnVec` pulses at T+5 with `dataIn`=0x5678_1234_DEAD_BEEF and `regToWrite`=3.
  - `done` coincides with the write.
- Scalar load, `destReg`=13, base 0x0020, data 0x0007.
  - `regWrEnSc` pulses at T+2 with `dataIn`=0x0000_0000_0000_0007.
  - Register file read of r13 returns 0x0007 in all lanes.
- Stalled memory: vector load with `memValid` low for 3 cycles before lane 2.
  - Write at T+8, data still in correct lane order.
- Illegal requests: vector to `destReg`=5, and scalar to 12.
  - `err` pulses, `memRd` stays 0, no write enable is asserted.
- Reset mid-operation: assert `reset` after 2 lanes are captured.
  - All outputs are 0 next cycle.
  - A following scalar load behaves normally.
- With `VLOAD_STRIDE_EN`: base 0xFFFE, stride 2.
  - Addresses 0xFFFE, 0x0000, 0x0002, 0x0004 (wrap).
- Without the macro, the same base gives addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/vector_load_unit.sv
// Load/writeback stage: fetches one word per lane from memory, then issues one register-file write.
// Optional feature macro: VLOAD_STRIDE_EN adds a per-request lane address stride (default stride 1).
//
// state | meaning
// IDLE  | waiting for start; illegal requests pulse err
// FETCH | memRd high, one lane captured per memValid cycle
// WRITE | single-cycle register-file write, done pulse
module vector_load_unit #(
  parameter int registerSize     = 16,
  parameter int selectionBits    = 4,
  parameter int vectorSize       = 4,
  parameter int registerQuantity = 4,
  parameter int addrWidth        = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               isVector,
  input  logic [selectionBits-1:0]           destReg,
  input  logic [addrWidth-1:0]               baseAddr,
`ifdef VLOAD_STRIDE_EN
  input  logic [addrWidth-1:0]               stride,
`endif
  output logic                               memRd,
  output logic [addrWidth-1:0]               memAddr,
  input  logic [registerSize-1:0]            memRdData,
  input  logic                               memValid,
  output logic                               regWrEnSc,
  output logic                               regWrEnVec,
  output logic [selectionBits-1:0]           regToWrite,
  output logic [vectorSize*registerSize-1:0] dataIn,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam int DW = vectorSize * registerSize;
  localparam logic [selectionBits-1:0] REG_QTY  = selectionBits'(registerQuantity);
  localparam logic [selectionBits-1:0] ZERO_REG = selectionBits'(12);
  localparam logic [LW-1:0]            LAST_LANE = LW'(vectorSize - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t                   r_state;
  logic                     r_isvec;
  logic [selectionBits-1:0] r_dest;
  logic [addrWidth-1:0]     r_stride;
  logic [LW-1:0]            r_cnt;
  logic [DW-1:0]            r_buf;

  logic                     w_legal;
  logic                     w_last;
  logic [DW-1:0]            w_buf_next;
  logic [addrWidth-1:0]     w_stride_in;

`ifdef VLOAD_STRIDE_EN
  assign w_stride_in = stride;
`else
  assign w_stride_in = addrWidth'(1);
`endif

  // Register 12 is the hardwired zero register and can never be a scalar target.
  assign w_legal = isVector ? (destReg < REG_QTY)
                            : ((destReg >= REG_QTY) && (destReg != ZERO_REG));

  assign w_last = !r_isvec || (r_cnt == LAST_LANE);

  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < vectorSize; i++) begin
      if (r_cnt == LW'(i)) w_buf_next[i*registerSize +: registerSize] = memRdData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_isvec    <= 1'b0;
      r_dest     <= '0;
      r_stride   <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      memRd      <= 1'b0;
      memAddr    <= '0;
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_isvec  <= isVector;
            r_dest   <= destReg;
            r_stride <= w_stride_in;
            r_cnt    <= '0;
            r_buf    <= '0;
            if (w_legal) begin
              r_state <= FETCH;
              busy    <= 1'b1;
              memRd   <= 1'b1;
              memAddr <= baseAddr;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (memValid) begin
            r_buf <= w_buf_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state    <= WRITE;
              memRd      <= 1'b0;
              dataIn     <= w_buf_next;
              regToWrite <= r_dest;
              regWrEnVec <= r_isvec;
              regWrEnSc  <= !r_isvec;
              done       <= 1'b1;
            end else begin
              memAddr <= memAddr + r_stride;
            end
          end
        end
        WRITE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Table-driven bench for vector_load_unit with a write scoreboard and a register-file model.
// Honours VLOAD_STRIDE_EN when the design is built with it.
module tb_vector_load_unit;

  logic        clk = 1'b0;
  logic        reset, start, isVector;
  logic [3:0]  destReg;
  logic [15:0] baseAddr;
`ifdef VLOAD_STRIDE_EN
  logic [15:0] stride;
`endif
  logic        memRd;
  logic [15:0] memAddr;
  logic [15:0] memRdData;
  logic        memValid;
  logic        regWrEnSc, regWrEnVec;
  logic [3:0]  regToWrite;
  logic [63:0] dataIn;
  logic        busy, done, err;

  vector_load_unit dut (
    .clk(clk), .reset(reset), .start(start), .isVector(isVector),
    .destReg(destReg), .baseAddr(baseAddr),
`ifdef VLOAD_STRIDE_EN
    .stride(stride),
`endif
    .memRd(memRd), .memAddr(memAddr), .memRdData(memRdData), .memValid(memValid),
    .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite),
    .dataIn(dataIn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  dest;
    logic        isvec;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic            isvec;
    logic [3:0]      dest;
    logic [15:0]     base;
    logic [15:0]     strd;
    logic [3:0][15:0] d;
    int              stall_lane;
    int              stall_n;
    logic            legal;
    logic            hold_start;
    logic [63:0]     exp;
  } vec_t;

  wr_t         sbq[$];
  vec_t        tbl[10];
  vec_t        post;
  logic [63:0] rf[16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] base, input logic [15:0] s, input int k);
`ifdef VLOAD_STRIDE_EN
    return base + 16'(k) * s;
`else
    return base + 16'(k) + (s & 16'h0);
`endif
  endfunction

  task automatic check_reset_outs(input string name);
    chk({name, "_ctl"}, 64'({memRd, regWrEnSc, regWrEnVec, regToWrite, busy, done, err, memAddr}), 64'h0);
    chk({name, "_data"}, dataIn, 64'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int k;
    int stalls;
    int guard;
    logic [63:0] rfexp;
    n = v.isvec ? 4 : 1;
    k = 0;
    stalls = 0;
    guard = 0;
    start = 1'b1;
    isVector = v.isvec;
    destReg = v.dest;
    baseAddr = v.base;
`ifdef VLOAD_STRIDE_EN
    stride = v.strd;
`endif
    memValid = !v.legal;
    memRdData = 16'hFFFF;
    @(posedge clk); #1;
    if (!v.hold_start) start = 1'b0;
    if (!v.legal) begin
      chk($sformatf("t%0d err_pulse", idx), 64'(err), 64'h1);
      chk($sformatf("t%0d err_quiet", idx), 64'({busy, memRd, regWrEnSc, regWrEnVec, done}), 64'h0);
      @(posedge clk); #1;
      start = 1'b0;
      memValid = 1'b0;
      chk($sformatf("t%0d err_clear", idx), 64'({err, busy, memRd, regWrEnSc, regWrEnVec}), 64'h0);
      return;
    end
    sbq.push_back('{v.dest, v.isvec, v.exp, cyc + n + v.stall_n});
    if (v.hold_start) begin
      isVector = !v.isvec;
      destReg = 4'd9;
    end
    while (k < n && guard < 40) begin
      chk($sformatf("t%0d addr l%0d", idx, k), 64'({memRd, busy, memAddr}),
          64'({2'b11, exp_addr(v.base, v.strd, k)}));
      if (k == v.stall_lane && stalls < v.stall_n) begin
        memValid = 1'b0;
        stalls++;
      end else begin
        memValid = 1'b1;
        memRdData = v.d[k];
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    memValid = 1'b0;
    start = 1'b0;
    if (k < n) chk($sformatf("t%0d fetch_timeout", idx), 64'(k), 64'(n));
    chk($sformatf("t%0d write_cycle", idx), 64'({done, busy, memRd}), 64'b110);
    @(posedge clk); #1;
    chk($sformatf("t%0d after_write", idx),
        64'({done, busy, regWrEnSc, regWrEnVec, memRd, err}), 64'h0);
    chk($sformatf("t%0d hold_data", idx), dataIn, v.exp);
    chk($sformatf("t%0d hold_dest", idx), 64'(regToWrite), 64'(v.dest));
    rfexp = v.isvec ? v.exp : {4{v.exp[15:0]}};
    chk($sformatf("t%0d rf_read", idx), rf[v.dest], rfexp);
  endtask

  initial begin
    wr_t e;
    reset = 1'b1;
    start = 1'b0;
    isVector = 1'b0;
    destReg = '0;
    baseAddr = '0;
`ifdef VLOAD_STRIDE_EN
    stride = 16'h0001;
`endif
    memValid = 1'b0;
    memRdData = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    tbl[0] = '{1'b1, 4'd3,  16'h0010, 16'h0001, {16'h5678, 16'h1234, 16'hDEAD, 16'hBEEF}, -1, 0, 1'b1, 1'b0, 64'h5678_1234_DEAD_BEEF};
    tbl[1] = '{1'b0, 4'd13, 16'h0020, 16'h0005, {16'h9999, 16'h8888, 16'h7777, 16'h0007}, -1, 0, 1'b1, 1'b0, 64'h0000_0000_0000_0007};
    tbl[2] = '{1'b1, 4'd1,  16'h0100, 16'h0001, {16'h4444, 16'h3333, 16'h2222, 16'h1111},  2, 3, 1'b1, 1'b1, 64'h4444_3333_2222_1111};
    tbl[3] = '{1'b1, 4'd5,  16'h0200, 16'h0001, {16'h0, 16'h0, 16'h0, 16'h0},             -1, 0, 1'b0, 1'b0, 64'h0};
    tbl[4] = '{1'b0, 4'd12, 16'h0210, 16'h0001, {16'h0, 16'h0, 16'h0, 16'h0},             -1, 0, 1'b0, 1'b0, 64'h0};
    tbl[5] = '{1'b1, 4'd0,  16'hFFFE, 16'h0002, {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0}, -1, 0, 1'b1, 1'b0, 64'hD3D3_C2C2_B1B1_A0A0};
    tbl[6] = '{1'b0, 4'd15, 16'hFFFF, 16'h0003, {16'h0, 16'h0, 16'h0, 16'h8001},           0, 2, 1'b1, 1'b0, 64'h0000_0000_0000_8001};
    tbl[7] = '{1'b0, 4'd4,  16'h1234, 16'h0001, {16'h0, 16'h0, 16'h0, 16'hFFFF},          -1, 0, 1'b1, 1'b0, 64'h0000_0000_0000_FFFF};
    tbl[8] = '{1'b0, 4'd3,  16'h0400, 16'h0001, {16'h0, 16'h0, 16'h0, 16'h0},             -1, 0, 1'b0, 1'b0, 64'h0};
    tbl[9] = '{1'b1, 4'd3,  16'h0500, 16'h0001, {16'h0004, 16'h0003, 16'h0002, 16'h0001},  0, 1, 1'b1, 1'b0, 64'h0004_0003_0002_0001};
    post   = '{1'b0, 4'd14, 16'h0300, 16'h0001, {16'h0, 16'h0, 16'h0, 16'h00C3},          -1, 0, 1'b1, 1'b0, 64'h0000_0000_0000_00C3};

    fork
      forever begin
        @(negedge clk);
        if (regWrEnSc || regWrEnVec) begin
          chk("one_enable", 64'(regWrEnSc & regWrEnVec), 64'h0);
          chk("wr_done", 64'(done), 64'h1);
          if (sbq.size() == 0) begin
            chk("unexpected_write", 64'({regWrEnSc, regWrEnVec}), 64'h0);
          end else begin
            e = sbq.pop_front();
            chk("wr_vec_en", 64'(regWrEnVec), 64'(e.isvec));
            chk("wr_sc_en", 64'(regWrEnSc), 64'(!e.isvec));
            chk("wr_dest", 64'(regToWrite), 64'(e.dest));
            chk("wr_data", dataIn, e.data);
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          end
          rf[regToWrite] = regWrEnVec ? dataIn : {4{dataIn[15:0]}};
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Reset after two lanes have been captured: partial load must vanish.
    start = 1'b1;
    isVector = 1'b1;
    destReg = 4'd2;
    baseAddr = 16'h0040;
    sbq.push_back('{4'd2, 1'b1, 64'h0, 0});
    @(posedge clk); #1;
    start = 1'b0;
    memValid = 1'b1;
    memRdData = 16'hAAAA;
    @(posedge clk); #1;
    memRdData = 16'hBBBB;
    @(posedge clk); #1;
    chk("pre_reset_busy", 64'({busy, memRd}), 64'b11);
    memValid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outs("mid_reset");
    void'(sbq.pop_back());
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", 64'({busy, memRd, done}), 64'h0);
    chk("reset_rf_untouched", rf[2], 64'h0);
    run_vec(post, 10);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
